// File: rtl/mac_accumulator_if.sv
// Product-in / result-out bus of the multiply-accumulate stage.
// The slave modport is the accumulator; the master modport is its environment.
interface mac_accumulator_if #(
    parameter int unsigned PROD_W = 16,
    parameter int unsigned ACC_W  = 20,
    parameter int unsigned LEN    = 4
);
    localparam int unsigned CNT_W = $clog2(LEN);

    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] product;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              overflow;
    logic [CNT_W-1:0]  beat_cnt;

    modport master (
        output clear, in_valid, product, out_ready,
        input  in_ready, out_valid, acc_out, overflow, beat_cnt
    );

    modport slave (
        input  clear, in_valid, product, out_ready,
        output in_ready, out_valid, acc_out, overflow, beat_cnt
    );
endinterface

// File: rtl/mac_accumulator.sv
// Sums LEN consecutive unsigned products into one frame result, presented on a
// held valid/ready port together with a sticky carry-out flag.
module mac_accumulator #(
    parameter int unsigned PROD_W = 16,
    parameter int unsigned LEN    = 4,
    parameter int unsigned ACC_W  = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    mac_accumulator_if.slave    bus
);
    localparam int unsigned      CNT_W     = $clog2(LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LEN - 1);

    if (ACC_W < PROD_W) begin : g_bad_acc_w
        $error("mac_accumulator: ACC_W must be >= PROD_W");
    end
    if (LEN < 2) begin : g_bad_len
        $error("mac_accumulator: LEN must be >= 2");
    end

    typedef enum logic {S_ACC, S_DONE} state_t;

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic [CNT_W-1:0] beat_q;
    logic [ACC_W-1:0] acc_out_q;
    logic             overflow_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] acc_d;
    logic             ovf_d;
    logic             in_xfer;

    assign in_xfer = bus.in_valid && in_ready_q;

    // Next accumulator value for an accepted beat: first beat restarts the frame.
    always_comb begin
        prod_ext = ACC_W'(bus.product);
        sum_ext  = {1'b0, acc_q} + {1'b0, prod_ext};
        acc_d    = sum_ext[ACC_W-1:0];
        ovf_d    = ovf_q | sum_ext[ACC_W];
        if (beat_q == '0) begin
            acc_d = prod_ext;
            ovf_d = 1'b0;
        end
    end

    // Frame FSM with all outputs registered; clear outranks every other action.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            beat_q      <= '0;
            acc_out_q   <= '0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (bus.clear) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            beat_q      <= '0;
            acc_out_q   <= '0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_ACC: begin
                    // in_ready is low only for the first cycle after reset here.
                    in_ready_q <= 1'b1;
                    if (in_xfer) begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_d;
                        if (beat_q == LAST_BEAT) begin
                            acc_out_q   <= acc_d;
                            overflow_q  <= ovf_d;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            beat_q      <= '0;
                            state_q     <= S_DONE;
                        end else begin
                            beat_q <= beat_q + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_ACC;
                    end
                end
                default: begin
                    state_q     <= S_ACC;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_out_q;
    assign bus.overflow  = overflow_q;
    assign bus.beat_cnt  = beat_q;
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator with a frame-result scoreboard.
module tb_mac_accumulator;
    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] acc;
        logic        ovf;
    } res_t;

    res_t sb[$];
    res_t sb16[$];

    // Reference model state for the ACC_W=20 instance
    logic [19:0] m_acc;
    logic        m_ovf;
    int          m_cnt;

    mac_accumulator_if #(.PROD_W(16), .ACC_W(20), .LEN(4)) bus ();
    mac_accumulator_if #(.PROD_W(16), .ACC_W(16), .LEN(4)) bus16 ();

    mac_accumulator #(.PROD_W(16), .LEN(4), .ACC_W(20)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    mac_accumulator #(.PROD_W(16), .LEN(4), .ACC_W(16)) dut16 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = '0;
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_beat(input logic [15:0] p);
        logic [20:0] s;
        if (m_cnt == 0) begin
            m_acc = {4'b0, p};
            m_ovf = 1'b0;
        end else begin
            s     = {1'b0, m_acc} + {5'b0, p};
            m_acc = s[19:0];
            m_ovf = m_ovf | s[20];
        end
        m_cnt++;
        if (m_cnt == 4) begin
            sb.push_back('{acc: {12'b0, m_acc}, ovf: m_ovf});
            m_cnt = 0;
        end
    endtask

    // Offer one product after 'gap' idle cycles; returns 1 time unit after it is accepted.
    task automatic send(input logic [15:0] p, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        chk("beat_cnt_before_beat", 32'(bus.beat_cnt), 32'(m_cnt));
        bus.in_valid = 1'b1;
        bus.product  = p;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            model_beat(p);
        end
    endtask

    // Wait for a result, compare it against the scoreboard head; returns the expected sum.
    task automatic get_result(input string tag, output logic [31:0] exp_acc);
        int   n;
        res_t r;
        n = 0;
        exp_acc = '0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk({tag, "_out_valid_timeout"}, 32'(bus.out_valid), 32'd1);
        end else if (sb.size() == 0) begin
            chk({tag, "_unexpected_result"}, 32'(sb.size()), 32'd1);
        end else begin
            r = sb.pop_front();
            exp_acc = r.acc;
            chk({tag, "_acc_out"}, 32'(bus.acc_out), r.acc);
            chk({tag, "_overflow"}, 32'(bus.overflow), 32'(r.ovf));
        end
    endtask

    initial begin : stim
        logic [31:0] held;
        logic [15:0] p16 [4];
        logic [16:0] s16;
        logic [15:0] a16;
        logic        o16;
        res_t        r16;

        model_reset();
        rst_n           = 1'b0;
        bus.clear       = 1'b0;
        bus.in_valid    = 1'b0;
        bus.product     = '0;
        bus.out_ready   = 1'b1;
        bus16.clear     = 1'b0;
        bus16.in_valid  = 1'b0;
        bus16.product   = '0;
        bus16.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_acc_out", 32'(bus.acc_out), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_beat_cnt", 32'(bus.beat_cnt), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("in_ready_low_before_edge", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("in_ready_after_release", 32'(bus.in_ready), 32'd1);

        // Frame 1: back-to-back beats, one-cycle result latency, one-cycle in_ready drop
        send(16'd35, 0);
        send(16'd140, 0);
        send(16'd75, 0);
        send(16'd1210, 0);
        chk("f1_out_valid_latency", 32'(bus.out_valid), 32'd1);
        chk("f1_in_ready_low", 32'(bus.in_ready), 32'd0);
        get_result("f1", held);
        chk("f1_sum_value", held, 32'd1460);
        @(posedge clk);
        #1;
        chk("f1_out_valid_drop", 32'(bus.out_valid), 32'd0);
        chk("f1_in_ready_back", 32'(bus.in_ready), 32'd1);

        // Frame 2: 255*255 four times with random gaps
        for (int i = 0; i < 4; i++) send(16'd65025, int'($urandom_range(0, 3)));
        get_result("f2", held);
        chk("f2_sum_value", held, 32'd260100);
        @(posedge clk);
        #1;

        // Frame 3: result held under back-pressure, offered products ignored
        bus.out_ready = 1'b0;
        send(16'd1, 0);
        send(16'd2, 0);
        send(16'd3, 0);
        send(16'd4, 0);
        get_result("f3", held);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.product  = 16'd99;
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_acc_out", 32'(bus.acc_out), held);
            chk("hold_beat_cnt", 32'(bus.beat_cnt), 32'd0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(16'd99, 0);
        send(16'd0, 0);
        send(16'd0, 0);
        send(16'd0, 0);
        get_result("f4", held);
        @(posedge clk);
        #1;

        // Clear mid-frame with a product on the same cycle
        send(16'd500, 0);
        send(16'd500, 0);
        @(negedge clk);
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.product  = 16'd777;
        @(posedge clk);
        #1;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        model_reset();
        chk("clr_beat_cnt", 32'(bus.beat_cnt), 32'd0);
        chk("clr_in_ready", 32'(bus.in_ready), 32'd1);
        chk("clr_acc_out", 32'(bus.acc_out), 32'd0);
        for (int i = 0; i < 4; i++) send(16'd1, 0);
        get_result("f5", held);
        @(posedge clk);
        #1;

        // Clear while a result is pending discards it
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'd2, 0);
        @(negedge clk);
        chk("done_pending_valid", 32'(bus.out_valid), 32'd1);
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        bus.out_ready = 1'b1;
        if (sb.size() > 0) void'(sb.pop_front());
        chk("clr_done_out_valid", 32'(bus.out_valid), 32'd0);
        chk("clr_done_acc_out", 32'(bus.acc_out), 32'd0);
        chk("clr_done_in_ready", 32'(bus.in_ready), 32'd1);

        // Asynchronous reset mid-frame, with a previous result still on acc_out
        for (int i = 0; i < 4; i++) send(16'd3, 0);
        get_result("f6", held);
        @(posedge clk);
        #1;
        send(16'd3, 0);
        send(16'd3, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_acc_out", 32'(bus.acc_out), 32'd0);
        chk("arst_beat_cnt", 32'(bus.beat_cnt), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send(16'd7, 0);
        get_result("f7", held);
        chk("f7_sum_value", held, 32'd28);
        @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Narrow accumulator: wrap-around and sticky carry
        p16[0] = 16'd65025;
        p16[1] = 16'd65025;
        p16[2] = 16'd1;
        p16[3] = 16'd1;
        a16 = '0;
        o16 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s16 = {1'b0, a16} + {1'b0, p16[i]};
            a16 = (i == 0) ? p16[i] : s16[15:0];
            o16 = (i == 0) ? 1'b0 : (o16 | s16[16]);
        end
        sb16.push_back('{acc: {16'b0, a16}, ovf: o16});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("n16_in_ready", 32'(bus16.in_ready), 32'd1);
            bus16.in_valid = 1'b1;
            bus16.product  = p16[i];
        end
        @(negedge clk);
        bus16.in_valid = 1'b0;
        r16 = sb16.pop_front();
        chk("n16_out_valid", 32'(bus16.out_valid), 32'd1);
        chk("n16_acc_out", 32'(bus16.acc_out), r16.acc);
        chk("n16_overflow", 32'(bus16.overflow), 32'(r16.ovf));
        chk("n16_acc_value", 32'(bus16.acc_out), 32'd64516);
        chk("n16_ovf_value", 32'(bus16.overflow), 32'd1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
Sequential stage directly downstream of multiplier_wallace. It consumes the 16-bit product stream under a valid/ready handshake and sums LEN consecutive products into one accumulated result (dot-product frame). It presents the result on a held valid/ready output port with a sticky overflow flag, so the combinational multiplier can be used in a multiply-accumulate datapath.

Parameters:
PROD_W, 16, width of incoming product (matches multiplier_wallace output)
LEN, 4, products summed per frame (>= 2)
ACC_W, 20, accumulator width (>= PROD_W; PROD_W + clog2(LEN) guarantees no overflow)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous frame abort, active-high
in_valid  input  1  product is valid this cycle
in_ready  output  1  block accepts product this cycle
product  input  PROD_W  unsigned product from multiplier_wallace
out_valid  output  1  acc_out/overflow valid
out_ready  input  1  consumer takes result this cycle
acc_out  output  ACC_W  accumulated frame sum
overflow  output  1  carry out of ACC_W occurred during the frame
beat_cnt  output  clog2(LEN)  products accepted in the current frame

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (rst_n low, asynchronous): state=ACC, in_ready=0, out_valid=0, acc_out=0, overflow=0, beat_cnt=0, internal accumulator=0. in_ready is a register and rises on the first clk edge after rst_n deasserts.
- Reset mid-frame discards all partial sums. No result is emitted.
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- State ACC (in_ready=1, out_valid=0):
  - On a transfer with beat_cnt==0: acc <= zero-extended product and ovf <= 0, which starts a new frame.
  - Otherwise: acc <= (acc + product) mod 2^ACC_W, and ovf <= ovf | carry-out.
  - Each transfer increments beat_cnt. Cycles with in_valid low (gaps) leave all state unchanged.
  - On the transfer with beat_cnt==LEN-1:
    - acc_out <= final sum and overflow <= final ovf (including this beat's carry).
    - out_valid <= 1, in_ready <= 0, beat_cnt <= 0, next state DONE.
- Latency: out_valid is high in the cycle after the LEN-th accepted product.
- State DONE (out_valid=1, in_ready=0):
  - acc_out and overflow are held stable for as long as out_ready is low.
  - Products offered during DONE are not accepted.
  - On an out transfer: out_valid <= 0, in_ready <= 1, next state ACC. A new product can be accepted one cycle after the out transfer; there is no same-cycle bypass.
- clear (synchronous; lower priority than rst_n, higher than all else):
  - Next state ACC; acc, beat_cnt, ovf, acc_out and overflow become 0.
  - out_valid <= 0 and in_ready <= 1.
  - A product presented in the same cycle as clear is dropped.
  - clear during DONE discards the pending result.
- All arithmetic is unsigned. product is zero-extended to ACC_W. If ACC_W < PROD_W, behaviour is undefined; the implementation must reject this with a generate-time error.
- acc_out and overflow change only on the final beat of a frame, on clear, or on reset; they never show partial sums.

Test Plan:
- Reset release, then products 35, 140, 75, 1210 on consecutive cycles, out_ready=1 -> in_ready=1 one cycle after reset; out_valid one cycle after the 4th beat; acc_out=1460 (0x005B4), overflow=0; in_ready=0 for exactly one cycle.
- Four products of 65025 (255*255) with random in_valid gaps -> acc_out=260100 (0x3F804), overflow=0; beat_cnt counts 0..3 and ignores gap cycles.
- Override ACC_W=16, products 65025, 65025, 1, 1 -> acc_out=64516, overflow=1.
- Frame of 1, 2, 3, 4, then out_ready=0 for 5 cycles with in_valid=1, product=99 -> acc_out=10 stable, out_valid held, in_ready=0, no beats accepted. Then out_ready=1 and next frame 99, 0, 0, 0 -> acc_out=99.
- After 2 beats (500, 500), assert clear for one cycle, then frame 1, 1, 1, 1 -> acc_out=4; beat_cnt=0 after clear.
- Assert rst_n low asynchronously mid-frame (between edges) -> out_valid, acc_out, beat_cnt and in_ready go to 0 immediately. After release, frame 7, 7, 7, 7 -> acc_out=28.
